// File: rtl/cbus_arb_pkg.sv
// Shared types for the CBus arbiter: FSM state encoding, access-size codes,
// the latched control record and the grant-index width helper.
package cbus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef logic [1:0] msize_t;

    localparam msize_t MSIZE_BYTE = 2'd0;
    localparam msize_t MSIZE_HALF = 2'd1;
    localparam msize_t MSIZE_WORD = 2'd2;

    // Width-independent part of a master request, held for the whole transaction.
    // Address, strobe and data are held next to it because their widths depend on
    // the arbiter's parameters.
    typedef struct packed {
        logic   wr;
        msize_t size;
    } mreq_ctrl_t;

    // Grant index width; a single-port arbiter still carries a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cbus_arbiter_rr_picker.sv
// Combinational round-robin picker: the first requester found scanning upward
// from last_grant+1 (with wrap-around) wins. Built as a two-level priority
// search: requesters above last_grant first, then everyone from index 0.
module rr_picker
    import cbus_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     last_grant_i,
    output logic [NUM_PORTS-1:0] grant_oh_o,
    output logic [IDX_W-1:0]     grant_idx_o,
    output logic                 grant_valid_o
);

    logic [NUM_PORTS-1:0] req_hi;
    logic [NUM_PORTS-1:0] oh_hi;
    logic [NUM_PORTS-1:0] oh_lo;
    logic [NUM_PORTS:0]   seen_hi;
    logic [NUM_PORTS:0]   seen_lo;
    logic [IDX_W-1:0]     idx_acc [NUM_PORTS+1];

    assign seen_hi[0] = 1'b0;
    assign seen_lo[0] = 1'b0;
    assign idx_acc[0] = '0;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_scan
            // Ports strictly after the previous winner get first pick.
            assign req_hi[gi]      = req_i[gi] && (IDX_W'(gi) > last_grant_i);
            assign oh_hi[gi]       = req_hi[gi] && !seen_hi[gi];
            assign seen_hi[gi+1]   = seen_hi[gi] | req_hi[gi];
            assign oh_lo[gi]       = req_i[gi] && !seen_lo[gi];
            assign seen_lo[gi+1]   = seen_lo[gi] | req_i[gi];
            assign idx_acc[gi+1]   = idx_acc[gi] | (grant_oh_o[gi] ? IDX_W'(gi) : '0);
        end
    endgenerate

    assign grant_oh_o    = seen_hi[NUM_PORTS] ? oh_hi : oh_lo;
    assign grant_idx_o   = idx_acc[NUM_PORTS];
    assign grant_valid_o = seen_lo[NUM_PORTS];

endmodule

// File: rtl/cbus_arbiter.sv
// N-to-1 arbiter merging SRAM-like master ports onto one CBus channel with
// round-robin fairness and a single outstanding transaction.
// Optional: define CBUS_ARBITER_PERF_EN to add per-port grant counters and a
// stall-cycle counter (perf_grants / perf_stall).
module cbus_arbiter
    import cbus_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = idx_width(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            m_req,
    input  logic [NUM_PORTS-1:0]            m_wr,
    input  logic [NUM_PORTS*2-1:0]          m_size,
    input  logic [NUM_PORTS*ADDR_W-1:0]     m_addr,
    input  logic [NUM_PORTS*(DATA_W/8)-1:0] m_strobe,
    input  logic [NUM_PORTS*DATA_W-1:0]     m_wdata,
    output logic [NUM_PORTS-1:0]            m_addr_ok,
    output logic [NUM_PORTS-1:0]            m_data_ok,
    output logic [DATA_W-1:0]               m_rdata,
    output logic                            c_valid,
    output logic                            c_wr,
    output logic [1:0]                      c_size,
    output logic [ADDR_W-1:0]               c_addr,
    output logic [DATA_W/8-1:0]             c_strobe,
    output logic [DATA_W-1:0]               c_wdata,
    input  logic                            c_ready,
    input  logic                            c_last,
    input  logic [DATA_W-1:0]               c_rdata
`ifdef CBUS_ARBITER_PERF_EN
    ,
    output logic [NUM_PORTS*32-1:0]         perf_grants,
    output logic [31:0]                     perf_stall
`endif
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    mreq_ctrl_t          ctrl_q, ctrl_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [STRB_W-1:0]   strobe_q, strobe_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [NUM_PORTS-1:0] pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req_i         (m_req),
        .last_grant_i  (last_grant_q),
        .grant_oh_o    (pick_oh),
        .grant_idx_o   (pick_idx),
        .grant_valid_o (pick_valid)
    );

    // One-hot AND-OR mux of the winning port's request fields.
    logic [NUM_PORTS:0] sel_wr_acc;
    logic [1:0]         sel_size_acc   [NUM_PORTS+1];
    logic [ADDR_W-1:0]  sel_addr_acc   [NUM_PORTS+1];
    logic [STRB_W-1:0]  sel_strobe_acc [NUM_PORTS+1];
    logic [DATA_W-1:0]  sel_wdata_acc  [NUM_PORTS+1];

    assign sel_wr_acc[0]     = 1'b0;
    assign sel_size_acc[0]   = '0;
    assign sel_addr_acc[0]   = '0;
    assign sel_strobe_acc[0] = '0;
    assign sel_wdata_acc[0]  = '0;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_sel
            assign sel_wr_acc[gi+1]     = sel_wr_acc[gi] | (m_wr[gi] & pick_oh[gi]);
            assign sel_size_acc[gi+1]   = sel_size_acc[gi]
                                        | (m_size[gi*2 +: 2] & {2{pick_oh[gi]}});
            assign sel_addr_acc[gi+1]   = sel_addr_acc[gi]
                                        | (m_addr[gi*ADDR_W +: ADDR_W] & {ADDR_W{pick_oh[gi]}});
            assign sel_strobe_acc[gi+1] = sel_strobe_acc[gi]
                                        | (m_strobe[gi*STRB_W +: STRB_W] & {STRB_W{pick_oh[gi]}});
            assign sel_wdata_acc[gi+1]  = sel_wdata_acc[gi]
                                        | (m_wdata[gi*DATA_W +: DATA_W] & {DATA_W{pick_oh[gi]}});
        end
    endgenerate

    // State and latched-transaction registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
            grant_q      <= '0;
            ctrl_q       <= '0;
            addr_q       <= '0;
            strobe_q     <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            ctrl_q       <= ctrl_d;
            addr_q       <= addr_d;
            strobe_q     <= strobe_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, wait for the last CBus beat in BUSY,
    // spend exactly one cycle in RESP to hand data back.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        ctrl_d       = ctrl_q;
        addr_d       = addr_q;
        strobe_d     = strobe_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    ctrl_d.wr    = sel_wr_acc[NUM_PORTS];
                    ctrl_d.size  = sel_size_acc[NUM_PORTS];
                    addr_d       = sel_addr_acc[NUM_PORTS];
                    strobe_d     = sel_strobe_acc[NUM_PORTS];
                    wdata_d      = sel_wdata_acc[NUM_PORTS];
                    grant_d      = pick_idx;
                    last_grant_d = pick_idx;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                // Intermediate beats are accepted but only the final beat's data is kept.
                if (c_ready && c_last) begin
                    rdata_d = ctrl_q.wr ? '0 : c_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // addr_ok is combinational from m_req, so it is also gated by reset to keep
    // every master output low while reset is held.
    assign m_addr_ok = (!reset && state_q == IDLE) ? pick_oh : '0;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_data_ok
            assign m_data_ok[gi] = (state_q == RESP) && (grant_q == IDX_W'(gi));
        end
    endgenerate

    assign m_rdata  = (state_q == RESP) ? rdata_q : '0;
    assign c_valid  = (state_q == BUSY);
    assign c_wr     = ctrl_q.wr;
    assign c_size   = ctrl_q.size;
    assign c_addr   = addr_q;
    assign c_strobe = strobe_q;
    assign c_wdata  = wdata_q;

`ifdef CBUS_ARBITER_PERF_EN
    logic [31:0] grant_cnt_q [NUM_PORTS];
    logic [31:0] stall_cnt_q;
    logic        stall_hit;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_perf
            // Saturating count of grants issued to this port.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    grant_cnt_q[gi] <= '0;
                end else if (m_addr_ok[gi] && grant_cnt_q[gi] != '1) begin
                    grant_cnt_q[gi] <= grant_cnt_q[gi] + 32'd1;
                end
            end
            assign perf_grants[gi*32 +: 32] = grant_cnt_q[gi];
        end
    endgenerate

    // A cycle stalls when some port is requesting and is not being granted.
    assign stall_hit = |(m_req & ~m_addr_ok);

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall_hit && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_stall = stall_cnt_q;
`endif

endmodule
